// File: rtl/kgp_isa_pkg.sv
// Shared ISA constants for the KGPminiRISC front end: opcodes, jump-control encodings, fetch FSM states.
// Pure declarations, no logic; imported by the fetch unit and its next-PC helper.
// Optional build macro used by the importers: FETCH_MISALIGN_TRAP_EN.
package kgp_isa_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // Decoder CondJump field
    localparam logic [2:0] CJ_NONE = 3'b000;
    localparam logic [2:0] CJ_LTZ  = 3'b001;
    localparam logic [2:0] CJ_Z    = 3'b010;
    localparam logic [2:0] CJ_NZ   = 3'b011;
    localparam logic [2:0] CJ_CY   = 3'b100;
    localparam logic [2:0] CJ_NCY  = 3'b101;

    // Decoder AddrSel field; 2'b11 is reserved and never takes a jump
    localparam logic [1:0] AS_IMM26 = 2'b00;
    localparam logic [1:0] AS_REG   = 2'b01;
    localparam logic [1:0] AS_IMM16 = 2'b10;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC computation: branch condition, jump target and pc+4 link value.
// Purely combinational, zero latency; no handshake of its own.
// FETCH_MISALIGN_TRAP_EN: exposes misaligned_o instead of silently clearing target[1:0].
module next_pc_calc
    import kgp_isa_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [25:0]     imm26_i,
    input  logic [2:0]      cond_jump_i,
    input  logic            uncond_jump_i,
    input  logic [1:0]      addr_sel_i,
    input  logic [31:0]     rs_value_i,
    input  logic            carry_flag_i,
    output logic [PC_W-1:0] pc_plus4_o,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            misaligned_o,
`endif
    output logic [PC_W-1:0] next_pc_o
);

    localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};

    logic            cond;
    logic            sel_ok;
    logic            taken;
    logic [PC_W-1:0] target_raw;
    logic [PC_W-1:0] target;

    assign pc_plus4_o = pc_i + PC_W'(4);

    // Evaluate the branch condition and the raw target for the selected addressing mode
    always_comb begin
        cond = 1'b0;
        case (cond_jump_i)
            CJ_LTZ:  cond = rs_value_i[31];
            CJ_Z:    cond = (rs_value_i == 32'd0);
            CJ_NZ:   cond = (rs_value_i != 32'd0);
            CJ_CY:   cond = carry_flag_i;
            CJ_NCY:  cond = ~carry_flag_i;
            default: cond = 1'b0;
        endcase

        sel_ok     = 1'b1;
        target_raw = pc_plus4_o;
        case (addr_sel_i)
            AS_IMM26: target_raw = pc_i + {{(PC_W-26){imm26_i[25]}}, imm26_i};
            AS_REG:   target_raw = rs_value_i[PC_W-1:0];
            AS_IMM16: target_raw = pc_i + {{(PC_W-16){imm26_i[15]}}, imm26_i[15:0]};
            default:  sel_ok     = 1'b0;
        endcase

        taken = sel_ok & (uncond_jump_i | cond);
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Target passes through untouched; the fetch unit decides to trap on low bits
    assign target       = target_raw;
    assign misaligned_o = taken & (target_raw[1:0] != 2'b00);
`else
    // Word-align the target and keep running
    assign target = target_raw & ALIGN_MASK;
`endif

    assign next_pc_o = taken ? target : pc_plus4_o;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch / PC unit: REQ reads imem at pc, ISSUE presents the instruction until accepted.
// Latency: 2 cycles per instruction minimum (REQ then ISSUE with immediate ready).
// Backpressure: instr_ready low holds instr/pc/instr_valid without re-fetch. Macro: FETCH_MISALIGN_TRAP_EN.
module fetch_pc_unit
    import kgp_isa_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [5:0]      opcode,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    input  logic [2:0]      cond_jump,
    input  logic            uncond_jump,
    input  logic [1:0]      addr_sel,
    input  logic [31:0]     rs_value,
    input  logic            carry_flag,
    output logic            halted,
    output logic            misalign
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] next_pc;
    logic            handshake;
    logic            halt_op;
    logic            trap;

    assign handshake = (state_q == ST_ISSUE) & instr_ready;
    assign halt_op   = (instr_q[31:26] == OP_HALT);

    next_pc_calc #(
        .PC_W (PC_W)
    ) u_next_pc (
        .pc_i          (pc_q),
        .imm26_i       (instr_q[25:0]),
        .cond_jump_i   (cond_jump),
        .uncond_jump_i (uncond_jump),
        .addr_sel_i    (addr_sel),
        .rs_value_i    (rs_value),
        .carry_flag_i  (carry_flag),
        .pc_plus4_o    (pc_plus4),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misaligned_o  (trap),
`endif
        .next_pc_o     (next_pc)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    // Misalignment flag is sticky until reset; HALT opcode takes precedence over a trap
    always_comb begin
        misalign_d = misalign_q | (handshake & ~halt_op & trap);
    end

    // Misalignment flag register
    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end

    assign misalign = misalign_q;
`else
    assign trap     = 1'b0;
    assign misalign = 1'b0;
`endif

    // State, PC and instruction registers; reset wins over any handshake in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state logic: REQ always moves on, ISSUE waits for the handshake, HALT is terminal
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ:   state_d = ST_ISSUE;
            ST_ISSUE: if (handshake) state_d = (halt_op | trap) ? ST_HALT : ST_REQ;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_REQ;
        endcase
    end

    // Datapath next values: capture read data in REQ, advance PC only on a non-halting handshake
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (state_q == ST_REQ) instr_d = imem_rdata;
        if (handshake && !halt_op && !trap) pc_d = next_pc;
    end

    // Moore outputs decoded from the current state
    always_comb begin
        imem_en     = (state_q == ST_REQ) & ~rst;
        instr_valid = (state_q == ST_ISSUE);
        halted      = (state_q == ST_HALT);
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign opcode    = instr_q[31:26];

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed program in a behavioural memory, scoreboard monitor.
// Expected fetch addresses and issued instructions are queued by the stimulus and popped by the monitor.
// Build with or without FETCH_MISALIGN_TRAP_EN; the br-to-0x102 step checks the matching behaviour.
module tb_fetch_pc_unit;
    import kgp_isa_pkg::*;

    localparam int PC_W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [2:0]  cond_jump;
    logic        uncond_jump;
    logic [1:0]  addr_sel;
    logic [31:0] rs_value;
    logic        carry_flag;
    logic        halted;
    logic        misalign;

    fetch_pc_unit #(.PC_W(PC_W), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .cond_jump   (cond_jump),
        .uncond_jump (uncond_jump),
        .addr_sel    (addr_sel),
        .rs_value    (rs_value),
        .carry_flag  (carry_flag),
        .halted      (halted),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    // Memory model: read data for the presented address is what the DUT samples on the next edge
    logic [31:0] mem [0:127];
    assign imem_rdata = mem[imem_addr[8:2]];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } iss_t;

    logic [31:0] exp_addr_q[$];
    iss_t        exp_iss_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_hs  = -100;
    int hs_gap   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every fetch and every handshake is compared against the scoreboard queues
    always @(negedge clk) begin
        iss_t e;
        logic [31:0] a;
        cyc++;
        if (imem_en) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_fetch actual=%h required=none", imem_addr);
            end else begin
                a = exp_addr_q.pop_front();
                chk("fetch_addr", imem_addr, a);
            end
        end
        if (instr_valid && instr_ready) begin
            hs_gap  = cyc - last_hs;
            last_hs = cyc;
            if (exp_iss_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue actual_pc=%h required=none", pc);
            end else begin
                e = exp_iss_q.pop_front();
                chk("issue_pc", pc, e.pc);
                chk("issue_instr", instr, e.instr);
                chk("issue_opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
                chk("issue_pc_plus4", pc_plus4, e.pc4);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 40) begin
            tick;
            n++;
        end
        if (!instr_valid) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_valid required=instr_valid", name);
        end
    endtask

    // Present decoder controls for the instruction at epc and accept it; optionally queue the next fetch
    task automatic do_instr(input logic [31:0] epc, input logic [2:0] cj, input logic uj,
                            input logic [1:0] as, input logic [31:0] rs, input logic cy,
                            input bit push, input logic [31:0] nxt);
        wait_valid("issue");
        if (!instr_valid) return;
        cond_jump   = cj;
        uncond_jump = uj;
        addr_sel    = as;
        rs_value    = rs;
        carry_flag  = cy;
        exp_iss_q.push_back('{epc, mem[epc[8:2]], epc + 32'd4});
        if (push) exp_addr_q.push_back(nxt);
        instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0000;
        mem[1]  = 32'h0000_0004;   // 0x04 nop, reserved AddrSel
        mem[2]  = 32'h0000_0ABC;   // 0x08 nop, payload for stall check
        mem[4]  = 32'h1000_FFF8;   // 0x10 beqz-style, imm16 = -8
        mem[5]  = 32'h0000_0010;   // 0x14 carry test, imm16 = 0x10
        mem[6]  = 32'h0000_0008;   // 0x18 no-carry test, imm16 = 8
        mem[8]  = 32'h0C00_0040;   // 0x20 bl, imm26 = 0x40
        mem[24] = 32'h1400_0000;   // 0x60 br
        mem[64] = 32'hFC00_0000;   // 0x100 halt

        rst         = 1'b1;
        instr_ready = 1'b0;
        cond_jump   = CJ_NONE;
        uncond_jump = 1'b0;
        addr_sel    = AS_IMM26;
        rs_value    = 32'd0;
        carry_flag  = 1'b0;

        repeat (3) tick;
        chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);

        exp_addr_q.push_back(32'h0);
        rst = 1'b0;

        // Sequential fetch with never-taken and reserved-AddrSel controls
        do_instr(32'h00, 3'b110,  1'b0, AS_IMM26, 32'd0, 1'b0, 1, 32'h04);
        do_instr(32'h04, CJ_NONE, 1'b1, 2'b11,    32'd0, 1'b0, 1, 32'h08);
        chk("handshake_gap", 32'(hs_gap), 32'd2);

        // Backpressure: five cycles in ISSUE with ready low
        wait_valid("stall");
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", pc, 32'h08);
            chk("stall_instr", instr, 32'h0000_0ABC);
        end
        do_instr(32'h08, CJ_NONE, 1'b0, AS_IMM26, 32'd0, 1'b0, 1, 32'h0C);
        do_instr(32'h0C, CJ_NONE, 1'b0, AS_IMM26, 32'd0, 1'b0, 1, 32'h10);

        // Conditional on rs==0 with imm16: taken to 0x08, then not taken to 0x14
        do_instr(32'h10, CJ_Z,    1'b0, AS_IMM16, 32'd0, 1'b0, 1, 32'h08);
        do_instr(32'h08, CJ_NONE, 1'b0, AS_IMM26, 32'd0, 1'b0, 1, 32'h0C);
        do_instr(32'h0C, CJ_NONE, 1'b0, AS_IMM26, 32'd0, 1'b0, 1, 32'h10);
        do_instr(32'h10, CJ_Z,    1'b0, AS_IMM16, 32'd5, 1'b0, 1, 32'h14);

        // Carry-flag conditions: CY with carry=0 falls through, NCY with carry=0 jumps 0x18+8
        do_instr(32'h14, CJ_CY,   1'b0, AS_IMM16, 32'd0, 1'b0, 1, 32'h18);
        do_instr(32'h18, CJ_NCY,  1'b0, AS_IMM16, 32'd0, 1'b0, 1, 32'h20);

        // bl: unconditional imm26 jump 0x20+0x40, link value 0x24 checked by the monitor
        do_instr(32'h20, CJ_NONE, 1'b1, AS_IMM26, 32'd0, 1'b0, 1, 32'h60);

`ifdef FETCH_MISALIGN_TRAP_EN
        // br to 0x102 traps: HALT, sticky misalign, pc stays at 0x60
        do_instr(32'h60, CJ_NONE, 1'b1, AS_REG, 32'h102, 1'b0, 0, 32'h0);
        tick;
        chk("trap_halted", {31'd0, halted}, 32'd1);
        chk("trap_misalign", {31'd0, misalign}, 32'd1);
        chk("trap_pc", pc, 32'h60);
        chk("trap_valid", {31'd0, instr_valid}, 32'd0);
        repeat (3) tick;
`else
        // br to 0x102 is word-aligned to 0x100, which holds HALT
        do_instr(32'h60, CJ_NONE, 1'b1, AS_REG, 32'h102, 1'b0, 1, 32'h100);
        chk("br_misalign", {31'd0, misalign}, 32'd0);
        do_instr(32'h100, CJ_NONE, 1'b0, AS_IMM26, 32'd0, 1'b0, 0, 32'h0);
        tick;
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_pc", pc, 32'h100);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        end
`endif

        // Reset out of HALT
        rst = 1'b1;
        tick;
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_misalign", {31'd0, misalign}, 32'd0);
        chk("rst2_pc", pc, 32'h0);
        exp_addr_q.push_back(32'h0);
        rst = 1'b0;

        // Reset asserted during a handshake discards it
        wait_valid("rst_hs");
        cond_jump   = CJ_NONE;
        uncond_jump = 1'b0;
        addr_sel    = AS_IMM26;
        exp_iss_q.push_back('{32'h0, mem[0], 32'h4});
        instr_ready = 1'b1;
        rst         = 1'b1;
        tick;
        instr_ready = 1'b0;
        chk("rsths_pc", pc, 32'h0);
        chk("rsths_valid", {31'd0, instr_valid}, 32'd0);
        chk("rsths_imem_en", {31'd0, imem_en}, 32'd0);
        chk("rsths_instr", instr, 32'h0);
        chk("rsths_halted", {31'd0, halted}, 32'd0);
        exp_addr_q.push_back(32'h0);
        rst = 1'b0;

        do_instr(32'h00, CJ_NONE, 1'b0, AS_IMM26, 32'd0, 1'b0, 1, 32'h04);
        repeat (3) tick;

        chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("issue_queue_empty", 32'(exp_iss_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
